// File: rtl/fighter_pkg.sv
// Shared state encodings, default frame constants and stun-length helper
// for the per-player fighter action FSM.
package fighter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_BACKWARD   = 4'd1,
    ST_FORWARD    = 4'd2,
    ST_ATK_START  = 4'd3,
    ST_ATK_ACTIVE = 4'd4,
    ST_ATK_REC    = 4'd5,
    ST_DIR_START  = 4'd6,
    ST_DIR_ACTIVE = 4'd7,
    ST_DIR_REC    = 4'd8,
    ST_HITSTUN    = 4'd9,
    ST_BLOCKSTUN  = 4'd10
  } state_e;

  localparam int DEF_CNT_W      = 6;
  localparam int DEF_ATK_START  = 5;
  localparam int DEF_ATK_ACTIVE = 2;
  localparam int DEF_ATK_REC    = 16;
  localparam int DEF_DIR_START  = 4;
  localparam int DEF_DIR_ACTIVE = 3;
  localparam int DEF_DIR_REC    = 15;
  localparam int DEF_HIT_OFS    = 1;
  localparam int DEF_BLK_OFS    = 3;
  localparam int DEF_BUF_FRAMES = 4;

  // Stun frames = attacker's recovery minus the hit or block offset.
  function automatic int stun_frames(
    input logic dir,
    input logic blk,
    input int   atk_rec,
    input int   dir_rec,
    input int   hit_ofs,
    input int   blk_ofs
  );
    return (dir ? dir_rec : atk_rec) - (blk ? blk_ofs : hit_ofs);
  endfunction

endpackage

// File: rtl/fighter_frame_timer.sv
// Per-state frame counter: advances on frame ticks, clears on state change,
// saturates at all-ones, flags when it equals the terminal frame.
module fighter_frame_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count frames; a clear on a tick restarts the state at frame 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick_i) begin
      if (clr_i) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == term_i);

endmodule

// File: rtl/fighter_action_fsm.sv
// Per-player action FSM: movement, neutral/directional attacks, stun states.
// Optional input buffering at the end of recovery: FIGHTER_INPUT_BUFFER_EN.
module fighter_action_fsm
  import fighter_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ATK_START  = DEF_ATK_START,
  parameter int ATK_ACTIVE = DEF_ATK_ACTIVE,
  parameter int ATK_REC    = DEF_ATK_REC,
  parameter int DIR_START  = DEF_DIR_START,
  parameter int DIR_ACTIVE = DEF_DIR_ACTIVE,
  parameter int DIR_REC    = DEF_DIR_REC,
  parameter int HIT_OFS    = DEF_HIT_OFS,
  parameter int BLK_OFS    = DEF_BLK_OFS,
  parameter int BUF_FRAMES = DEF_BUF_FRAMES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             left,
  input  logic             right,
  input  logic             attack,
  input  logic             got_hit,
  input  logic             got_blocked,
  input  logic             hit_by_dir,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] frame_idx,
  output logic             move_flag,
  output logic             attack_flag,
  output logic             dir_atk_flag,
  output logic             hitbox_on,
  output logic             action_done
);

  localparam int MIN_REC = (ATK_REC < DIR_REC) ? ATK_REC : DIR_REC;
  localparam int MAX_CNT = 2 ** CNT_W;

  if (ATK_START < 1 || ATK_ACTIVE < 1 || ATK_REC < 1 ||
      DIR_START < 1 || DIR_ACTIVE < 1 || DIR_REC < 1 ||
      ATK_START >= MAX_CNT || ATK_ACTIVE >= MAX_CNT ||
      ATK_REC >= MAX_CNT || DIR_START >= MAX_CNT ||
      DIR_ACTIVE >= MAX_CNT || DIR_REC >= MAX_CNT ||
      HIT_OFS >= MIN_REC || BLK_OFS >= MIN_REC ||
      HIT_OFS < 0 || BLK_OFS < 0 ||
      BUF_FRAMES < 0 || BUF_FRAMES > MIN_REC) begin : g_bad_cfg
    $error("fighter_action_fsm: illegal frame timing parameters");
  end

  localparam logic [CNT_W-1:0] T_AS = CNT_W'(ATK_START - 1);
  localparam logic [CNT_W-1:0] T_AA = CNT_W'(ATK_ACTIVE - 1);
  localparam logic [CNT_W-1:0] T_AR = CNT_W'(ATK_REC - 1);
  localparam logic [CNT_W-1:0] T_DS = CNT_W'(DIR_START - 1);
  localparam logic [CNT_W-1:0] T_DA = CNT_W'(DIR_ACTIVE - 1);
  localparam logic [CNT_W-1:0] T_DR = CNT_W'(DIR_REC - 1);

  state_e           state_q, state_d;
  state_e           rec_exit;
  logic [CNT_W-1:0] stun_q, stun_d, stun_len;
  logic [CNT_W-1:0] term, cnt;
  logic             term_hit, restart, clr;
  logic             done_q, done_d;

  // Hit wins over block, so the offset is the block one only without a hit.
  assign stun_len = CNT_W'(stun_frames(hit_by_dir, ~got_hit,
                                       ATK_REC, DIR_REC,
                                       HIT_OFS, BLK_OFS));

  // Terminal frame index for the current timed state.
  always_comb begin
    term = '1;
    case (state_q)
      ST_ATK_START:  term = T_AS;
      ST_ATK_ACTIVE: term = T_AA;
      ST_ATK_REC:    term = T_AR;
      ST_DIR_START:  term = T_DS;
      ST_DIR_ACTIVE: term = T_DA;
      ST_DIR_REC:    term = T_DR;
      ST_HITSTUN,
      ST_BLOCKSTUN:  term = stun_q - CNT_W'(1);
      default:       term = '1;
    endcase
  end

  // Next-state decode; a hit preempts everything, including a running stun.
  always_comb begin
    state_d = state_q;
    stun_d  = stun_q;
    restart = 1'b0;
    done_d  = 1'b0;
    if (got_hit) begin
      state_d = ST_HITSTUN;
      stun_d  = stun_len;
      restart = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_BACKWARD, ST_FORWARD: begin
          if (got_blocked) begin
            state_d = ST_BLOCKSTUN;
            stun_d  = stun_len;
          end else if (attack && (left ^ right)) begin
            state_d = ST_DIR_START;
          end else if (attack && !left && !right) begin
            state_d = ST_ATK_START;
          end else if (left && !right) begin
            state_d = ST_BACKWARD;
          end else if (right && !left) begin
            state_d = ST_FORWARD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ATK_START:
          if (term_hit) state_d = ST_ATK_ACTIVE;
        ST_ATK_ACTIVE:
          if (term_hit) state_d = ST_ATK_REC;
        ST_DIR_START:
          if (term_hit) state_d = ST_DIR_ACTIVE;
        ST_DIR_ACTIVE:
          if (term_hit) state_d = ST_DIR_REC;
        ST_ATK_REC, ST_DIR_REC:
          if (term_hit) begin
            state_d = rec_exit;
            done_d  = 1'b1;
          end
        ST_HITSTUN, ST_BLOCKSTUN:
          if (term_hit) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign clr = restart | (state_d != state_q);

  // State, latched stun length and completion pulse; moves only on ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stun_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= frame_tick & done_d;
      if (frame_tick) begin
        state_q <= state_d;
        stun_q  <= stun_d;
      end
    end
  end

`ifdef FIGHTER_INPUT_BUFFER_EN
  localparam logic [CNT_W-1:0] W_A = CNT_W'(ATK_REC - BUF_FRAMES);
  localparam logic [CNT_W-1:0] W_D = CNT_W'(DIR_REC - BUF_FRAMES);

  logic buf_q, buf_dir_q, in_win, smp, in_rec;

  assign in_rec = (state_q == ST_ATK_REC) || (state_q == ST_DIR_REC);
  assign in_win = (state_q == ST_ATK_REC && cnt >= W_A) ||
                  (state_q == ST_DIR_REC && cnt >= W_D);
  assign smp    = attack & in_win;

  // A press on the exit tick itself counts as buffered too.
  always_comb begin
    rec_exit = ST_IDLE;
    if (smp) begin
      rec_exit = (left ^ right) ? ST_DIR_START : ST_ATK_START;
    end else if (buf_q) begin
      rec_exit = buf_dir_q ? ST_DIR_START : ST_ATK_START;
    end
  end

  // Buffer lives only while recovery continues; any exit or hit drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q     <= 1'b0;
      buf_dir_q <= 1'b0;
    end else if (frame_tick) begin
      if (in_rec && state_d == state_q) begin
        buf_q <= buf_q | smp;
        if (smp) buf_dir_q <= left ^ right;
      end else begin
        buf_q <= 1'b0;
      end
    end
  end
`else
  assign rec_exit = ST_IDLE;
`endif

  fighter_frame_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .tick_i (frame_tick),
    .clr_i  (clr),
    .term_i (term),
    .cnt_o  (cnt),
    .term_o (term_hit)
  );

  assign state        = state_q;
  assign frame_idx    = cnt;
  assign action_done  = done_q;
  assign move_flag    = (state_q == ST_BACKWARD) ||
                        (state_q == ST_FORWARD);
  assign attack_flag  = (state_q == ST_ATK_START) ||
                        (state_q == ST_ATK_ACTIVE);
  assign dir_atk_flag = (state_q == ST_DIR_START) ||
                        (state_q == ST_DIR_ACTIVE);
  assign hitbox_on    = (state_q == ST_ATK_ACTIVE) ||
                        (state_q == ST_DIR_ACTIVE);

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Scoreboard bench for fighter_action_fsm with default frame timing.
// Buffer scenario expectations follow FIGHTER_INPUT_BUFFER_EN.
module tb_fighter_action_fsm;
  import fighter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       left = 1'b0, right = 1'b0, attack = 1'b0;
  logic       got_hit = 1'b0, got_blocked = 1'b0, hit_by_dir = 1'b0;
  logic [3:0] state;
  logic [5:0] frame_idx;
  logic       move_flag, attack_flag, dir_atk_flag, hitbox_on;
  logic       action_done;

  always #5 clk = ~clk;

  fighter_action_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .left         (left),
    .right        (right),
    .attack       (attack),
    .got_hit      (got_hit),
    .got_blocked  (got_blocked),
    .hit_by_dir   (hit_by_dir),
    .state        (state),
    .frame_idx    (frame_idx),
    .move_flag    (move_flag),
    .attack_flag  (attack_flag),
    .dir_atk_flag (dir_atk_flag),
    .hitbox_on    (hitbox_on),
    .action_done  (action_done)
  );

  typedef struct {
    logic [3:0] st;
    logic [5:0] idx;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want,
               $time);
    end
  endtask

  // Expected {move, attack, dir_atk, hitbox} for a state.
  function automatic logic [3:0] flags_of(input logic [3:0] s);
    case (s)
      4'd1, 4'd2: return 4'b1000;
      4'd3:       return 4'b0100;
      4'd4:       return 4'b0101;
      4'd6:       return 4'b0010;
      4'd7:       return 4'b0011;
      default:    return 4'b0000;
    endcase
  endfunction

  task automatic push_run(input state_e s, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{st: s, idx: 6'(first + i), done: 1'b0});
    end
  endtask

  task automatic push_exit(input state_e s);
    exp_q.push_back('{st: s, idx: 6'd0, done: 1'b1});
  endtask

  task automatic tick(input logic l, input logic r, input logic a,
                      input logic h, input logic b, input logic d);
    exp_t e;
    @(negedge clk);
    left = l; right = r; attack = a;
    got_hit = h; got_blocked = b; hit_by_dir = d;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("frame_idx", 32'(frame_idx), 32'(e.idx));
      chk("action_done", 32'(action_done), 32'(e.done));
      chk("flags", 32'({move_flag, attack_flag, dir_atk_flag, hitbox_on}),
          32'(flags_of(e.st)));
      if (e.done) begin
        @(posedge clk);
        #1;
        chk("done_clear", 32'(action_done), 32'd0);
      end
    end
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    left = 0; right = 0; attack = 0;
    got_hit = 0; got_blocked = 0; hit_by_dir = 0;
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_idx", 32'(frame_idx), 32'd0);
    chk("rst_done", 32'(action_done), 32'd0);
    chk("rst_flags",
        32'({move_flag, attack_flag, dir_atk_flag, hitbox_on}), 32'd0);
  endtask

  initial begin
    // Neutral attack full cycle.
    do_reset();
    push_run(ST_ATK_START, 0, 5);
    push_run(ST_ATK_ACTIVE, 0, 2);
    push_run(ST_ATK_REC, 0, 16);
    push_exit(ST_IDLE);
    tick(0, 0, 1, 0, 0, 0);
    idle_ticks(23);

    // Directional attack full cycle.
    do_reset();
    push_run(ST_DIR_START, 0, 4);
    push_run(ST_DIR_ACTIVE, 0, 3);
    push_run(ST_DIR_REC, 0, 15);
    push_exit(ST_IDLE);
    tick(0, 1, 1, 0, 0, 0);
    idle_ticks(22);

    // Movement and the left+right+attack corner.
    push_run(ST_BACKWARD, 0, 2);
    push_run(ST_FORWARD, 0, 1);
    push_run(ST_IDLE, 0, 2);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);

    // Hitstun from neutral hit, blockstun from directional block.
    do_reset();
    push_run(ST_HITSTUN, 0, 15);
    push_exit(ST_IDLE);
    tick(0, 0, 0, 1, 0, 0);
    idle_ticks(15);
    do_reset();
    push_run(ST_BLOCKSTUN, 0, 12);
    push_exit(ST_IDLE);
    tick(0, 0, 0, 0, 1, 1);
    idle_ticks(12);

    // Counter-hit on the second active frame.
    do_reset();
    push_run(ST_ATK_START, 0, 5);
    push_run(ST_ATK_ACTIVE, 0, 2);
    push_run(ST_HITSTUN, 0, 15);
    push_exit(ST_IDLE);
    tick(0, 0, 1, 0, 0, 0);
    idle_ticks(6);
    tick(0, 0, 0, 1, 0, 0);
    idle_ticks(15);

    // Block during active frames is ignored.
    do_reset();
    push_run(ST_ATK_START, 0, 5);
    push_run(ST_ATK_ACTIVE, 0, 2);
    push_run(ST_ATK_REC, 0, 16);
    push_exit(ST_IDLE);
    tick(0, 0, 1, 0, 0, 0);
    idle_ticks(6);
    tick(0, 0, 0, 0, 1, 0);
    idle_ticks(16);

    // Combo re-hit at frame 10, then hit+block together.
    do_reset();
    push_run(ST_HITSTUN, 0, 11);
    push_run(ST_HITSTUN, 0, 15);
    push_exit(ST_IDLE);
    tick(0, 0, 0, 1, 0, 0);
    idle_ticks(10);
    tick(0, 0, 0, 1, 0, 0);
    idle_ticks(15);
    push_run(ST_HITSTUN, 0, 14);
    push_exit(ST_IDLE);
    tick(0, 0, 0, 1, 1, 1);
    idle_ticks(14);

    // Hit during blockstun converts to full hitstun.
    push_run(ST_BLOCKSTUN, 0, 3);
    push_run(ST_HITSTUN, 0, 15);
    push_exit(ST_IDLE);
    tick(0, 0, 0, 0, 1, 0);
    idle_ticks(2);
    tick(0, 0, 0, 1, 0, 0);
    idle_ticks(15);

    // Late press at recovery frame 13.
    do_reset();
    push_run(ST_ATK_START, 0, 5);
    push_run(ST_ATK_ACTIVE, 0, 2);
    push_run(ST_ATK_REC, 0, 16);
`ifdef FIGHTER_INPUT_BUFFER_EN
    push_exit(ST_ATK_START);
    push_run(ST_ATK_START, 1, 4);
    push_run(ST_ATK_ACTIVE, 0, 2);
    push_run(ST_ATK_REC, 0, 16);
    push_exit(ST_IDLE);
`else
    push_exit(ST_IDLE);
`endif
    tick(0, 0, 1, 0, 0, 0);
    idle_ticks(6 + 14);
    tick(0, 0, 1, 0, 0, 0);
    idle_ticks(2);
`ifdef FIGHTER_INPUT_BUFFER_EN
    idle_ticks(23);
`endif

    // Press at recovery frame 10 is outside the window.
    do_reset();
    push_run(ST_ATK_START, 0, 5);
    push_run(ST_ATK_ACTIVE, 0, 2);
    push_run(ST_ATK_REC, 0, 16);
    push_exit(ST_IDLE);
    tick(0, 0, 1, 0, 0, 0);
    idle_ticks(6 + 11);
    tick(0, 0, 1, 0, 0, 0);
    idle_ticks(5);

    // No tick for 100 cycles freezes everything; then reset mid-recovery.
    do_reset();
    push_run(ST_ATK_START, 0, 3);
    tick(0, 0, 1, 0, 0, 0);
    idle_ticks(2);
    @(negedge clk);
    left = 1; attack = 1; got_hit = 1; got_blocked = 1;
    repeat (100) @(posedge clk);
    #1;
    chk("freeze_state", 32'(state), 32'(ST_ATK_START));
    chk("freeze_idx", 32'(frame_idx), 32'd2);
    chk("freeze_done", 32'(action_done), 32'd0);
    push_run(ST_ATK_START, 3, 2);
    push_run(ST_ATK_ACTIVE, 0, 2);
    push_run(ST_ATK_REC, 0, 5);
    idle_ticks(9);
    do_reset();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
